// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch, 2-entry response FIFO, branch redirect.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_fault;

  logic [31:0] w_target;
  logic        w_empty;
  logic        w_hs;
  logic        w_push;
  logic        w_pop;

  // Offset arrives pre-biased by -12 from the comparator; undo the bias here.
  assign w_target = br_pc + br_offset + 32'd12;
  assign w_empty  = (r_count == 2'd0);

  assign imem_req_valid = (r_state == ST_REQ) && (r_count != 2'd2);
  assign imem_req_addr  = r_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;
  assign w_push         = (r_state == ST_WAIT) && imem_rsp_valid && !br_taken;
  assign w_pop          = !w_empty && id_ready && !br_taken;

  assign if_valid    = !w_empty;
  assign if_pc       = w_empty ? 32'd0 : r_fifo_pc[r_rd_ptr];
  assign if_instr    = w_empty ? 32'h0000_0013 : r_fifo_instr[r_rd_ptr];
  assign fetch_fault = r_fault;

  always_comb begin
    w_state_nxt = r_state;
    if (br_taken) begin
      // An accepted-but-unanswered request still owes a response that must be discarded.
      if ((((r_state == ST_WAIT) || (r_state == ST_DROP)) && !imem_rsp_valid) ||
          ((r_state == ST_REQ) && w_hs))
        w_state_nxt = ST_DROP;
      else
        w_state_nxt = ST_REQ;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_REQ;
        ST_REQ:  if (w_hs) w_state_nxt = ST_WAIT;
        ST_WAIT: if (imem_rsp_valid) w_state_nxt = ST_REQ;
        ST_DROP: if (imem_rsp_valid) w_state_nxt = ST_REQ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= br_taken && (w_target[1:0] != 2'b00);
      if (w_hs)
        r_req_pc <= r_pc;
      if (br_taken)
        r_pc <= {w_target[31:2], 2'b00};
      else if (w_hs)
        r_pc <= r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (br_taken) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push)
        r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_req_pc;
      r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized fetch traffic checked cycle by cycle against a queue-based model.
`default_nettype none
`timescale 1ns/1ps

module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_offset = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready = 1'b0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_taken       (br_taken),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_ready       (id_ready),
    .fetch_fault    (fetch_fault)
  );

  int checks = 0;
  int errors = 0;

  // Model: started = left reset cycle, m_out = request owed a response, m_drop = owed response is stale.
  bit          m_started, m_out, m_drop, m_fault;
  logic [31:0] m_pc, m_issued;
  logic [63:0] m_q[$];

  bit          mem_pend;
  int          mem_cnt;
  int          mem_dmin = 1;
  int          mem_dmax = 1;
  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_started = 0; m_out = 0; m_drop = 0; m_fault = 0;
    m_pc = RST_PC; m_issued = RST_PC;
    m_q.delete();
  endtask

  // Entered just after a negedge; leaves at the next negedge.
  task automatic cycle(input bit brt, input logic [31:0] bpc, input logic [31:0] boff,
                       input bit rdy, input bit idr);
    bit          exp_rv, hs, rsp;
    logic [31:0] rdata, t;
    br_taken = brt; br_pc = bpc; br_offset = boff;
    imem_req_ready = rdy; id_ready = idr;
    rsp = 0;
    rdata = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin rsp = 1; mem_pend = 0; end
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    exp_rv = m_started && !m_out && (m_q.size() < 2);
    chk("req_valid",   imem_req_valid, exp_rv);
    chk("req_addr",    imem_req_addr, m_pc);
    chk("if_valid",    if_valid, m_q.size() != 0);
    chk("if_pc",       if_pc, (m_q.size() != 0) ? m_q[0][63:32] : 32'd0);
    chk("if_instr",    if_instr, (m_q.size() != 0) ? m_q[0][31:0] : 32'h0000_0013);
    chk("fetch_fault", fetch_fault, m_fault);
    if (imem_req_valid && rdy) begin
      hs_log.push_back(imem_req_addr);
      mem_pend = 1;
      mem_cnt  = $urandom_range(mem_dmax, mem_dmin);
    end
    if (if_valid && idr) pop_log.push_back(if_pc);
    hs = exp_rv && rdy;
    if (m_q.size() != 0 && idr) void'(m_q.pop_front());
    m_fault = 0;
    if (brt) begin
      t = bpc + boff + 32'd12;
      m_fault = (t[1:0] != 2'b00);
      m_pc = t & ~32'h3;
      m_q.delete();
      m_out  = (m_out && !rsp) || hs;
      m_drop = m_out;
    end else if (hs) begin
      m_out = 1; m_drop = 0; m_issued = m_pc; m_pc = m_pc + 32'd4;
    end else if (m_out && rsp) begin
      if (!m_drop) m_q.push_back({m_issued, rdata});
      m_out = 0; m_drop = 0;
    end
    m_started = 1;
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs before any clock edge, releases on the next negedge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    br_taken = 0; imem_rsp_valid = 0; imem_req_ready = 0; id_ready = 0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr",  imem_req_addr, RST_PC);
    chk("rst_if_valid",  if_valid, 1'b0);
    chk("rst_if_pc",     if_pc, 32'd0);
    chk("rst_if_instr",  if_instr, 32'h0000_0013);
    chk("rst_fault",     fetch_fault, 1'b0);
    mem_pend = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hs_log.delete();
    pop_log.delete();
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Sequential fetch, 1-cycle memory, decode always ready.
    do_reset();
    mem_dmin = 1; mem_dmax = 1;
    repeat (12) cycle(0, 0, 0, 1, 1);
    chk("seq_hs0",  qget(hs_log, 0), 32'h100);
    chk("seq_hs1",  qget(hs_log, 1), 32'h104);
    chk("seq_hs2",  qget(hs_log, 2), 32'h108);
    chk("seq_pop0", qget(pop_log, 0), 32'h100);
    chk("seq_pop1", qget(pop_log, 1), 32'h104);
    chk("seq_pop2", qget(pop_log, 2), 32'h108);

    // Decode stalled: FIFO fills, requests stop, then resume in order.
    do_reset();
    repeat (10) cycle(0, 0, 0, 1, 0);
    chk("full_req_valid", imem_req_valid, 1'b0);
    chk("full_if_valid",  if_valid, 1'b1);
    chk("full_if_pc",     if_pc, 32'h100);
    chk("full_req_addr",  imem_req_addr, 32'h108);
    hs_log.delete(); pop_log.delete();
    repeat (8) cycle(0, 0, 0, 1, 1);
    chk("drain_pop0", qget(pop_log, 0), 32'h100);
    chk("drain_pop1", qget(pop_log, 1), 32'h104);
    chk("drain_hs0",  qget(hs_log, 0), 32'h108);
    chk("drain_pop2", qget(pop_log, 2), 32'h108);

    // Redirect while waiting: flush, drop the owed response, refetch at 0x22C.
    do_reset();
    mem_dmin = 1; mem_dmax = 1;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    mem_dmin = 3; mem_dmax = 3;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h200, 32'h20, 1, 0);
    chk("redir_flush",     if_valid, 1'b0);
    chk("redir_req_valid", imem_req_valid, 1'b0);
    chk("redir_addr",      imem_req_addr, 32'h22C);
    repeat (8) cycle(0, 0, 0, 1, 1);
    chk("redir_hs",  qget(hs_log, 2), 32'h22C);
    chk("redir_pop", qget(pop_log, 0), 32'h22C);

    // Misaligned target: one-cycle fault, aligned refetch.
    do_reset();
    mem_dmin = 1; mem_dmax = 1;
    cycle(1, 32'h200, 32'hFFFF_FFF6, 0, 1);
    chk("fault_pulse", fetch_fault, 1'b1);
    cycle(0, 0, 0, 1, 1);
    chk("fault_clear", fetch_fault, 1'b0);
    repeat (3) cycle(0, 0, 0, 1, 1);
    chk("fault_hs", qget(hs_log, 0), 32'h200);

    // PC wrap at the top of the address space.
    do_reset();
    cycle(1, 32'hFFFF_FFF0, 32'h0, 0, 1);
    repeat (6) cycle(0, 0, 0, 1, 1);
    chk("wrap_hs0", qget(hs_log, 0), 32'hFFFF_FFFC);
    chk("wrap_hs1", qget(hs_log, 1), 32'h0000_0000);

    // Reset while waiting; a stale response right after release is ignored.
    do_reset();
    mem_dmin = 3; mem_dmax = 3;
    repeat (3) cycle(0, 0, 0, 1, 1);
    do_reset();
    mem_pend = 1; mem_cnt = 1;
    mem_dmin = 1; mem_dmax = 1;
    repeat (7) cycle(0, 0, 0, 1, 1);
    chk("stale_hs0",  qget(hs_log, 0), RST_PC);
    chk("stale_pop0", qget(pop_log, 0), RST_PC);

    // Randomized traffic.
    do_reset();
    mem_dmin = 1; mem_dmax = 4;
    for (int i = 0; i < 3000; i++) begin
      bit          brt;
      logic [31:0] bpc, boff;
      brt  = ($urandom_range(0, 19) == 0);
      bpc  = $urandom;
      boff = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        bpc[1:0]  = 2'b00;
        boff[1:0] = 2'b00;
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(brt, bpc, boff, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 br_taken  in  1  SHALL be the branch-resolve strobe from the EX comparator.
REQ-005 br_pc  in  32  SHALL be the PC of the resolving branch.
REQ-006 br_offset  in  32  SHALL be the signed comparator offset, pre-biased by -12.
REQ-007 imem_req_valid  out  1  SHALL flag a valid fetch request.
REQ-008 imem_req_addr  out  32  SHALL carry the fetch address.
REQ-009 imem_req_ready  in  1  SHALL be the memory's request acceptance.
REQ-010 imem_rsp_valid  in  1  SHALL flag returned instruction data; it has no back-pressure.
REQ-011 imem_rsp_data  in  32  SHALL carry the returned instruction word.
REQ-012 if_valid  out  1  SHALL flag a fetched instruction available to decode.
REQ-013 if_pc  out  32  SHALL be the address of the presented instruction.
REQ-014 if_instr  out  32  SHALL be the presented instruction word.
REQ-015 id_ready  in  1  SHALL be decode acceptance; a pop occurs when if_valid & id_ready.
REQ-016 fetch_fault  out  1  SHALL pulse for one cycle on a misaligned redirect target.

Function
REQ-017 Redirect target SHALL be br_pc + br_offset + 32'd12, computed modulo 2^32.
REQ-018 Requests SHALL be handshaken on imem_req_valid & imem_req_ready; at most one request SHALL be outstanding.
REQ-019 A 2-entry FIFO of {pc, instr} SHALL hold responses; if_valid = FIFO non-empty; if_pc/if_instr = head entry, else 0 and 32'h0000_0013.
REQ-020 imem_req_valid SHALL be asserted only in state REQ and only when FIFO count < 2.
REQ-021 imem_req_addr and imem_req_valid SHALL be held stable until handshake, except on redirect.
REQ-022 On handshake without redirect, the PC SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-023 The issued address SHALL be captured, and the matching response SHALL be pushed with that address.
REQ-024 States: IDLE (reset), REQ, WAIT, DROP. IDLE -> REQ unconditionally on the next cycle.
REQ-025 REQ -> WAIT on handshake.
REQ-026 WAIT -> REQ on imem_rsp_valid, with the response pushed.
REQ-027 DROP -> REQ on imem_rsp_valid, with the response discarded.
REQ-028 imem_rsp_valid SHALL be ignored in IDLE and REQ.
REQ-029 On br_taken, redirect SHALL take priority over all same-cycle events.
REQ-030 On redirect, the FIFO SHALL be flushed (count 0, same-cycle push and pop discarded) and the PC SHALL load the target.
REQ-031 Redirect next state SHALL be DROP if in WAIT without same-cycle rsp, in REQ with same-cycle handshake, or in DROP without same-cycle rsp; otherwise REQ.
REQ-032 Target[1:0] != 0 SHALL pulse fetch_fault in the cycle after br_taken, and the PC SHALL load the target with bits [1:0] cleared.
REQ-033 A simultaneous push and pop with FIFO full SHALL be impossible by REQ-020; a simultaneous push and pop otherwise SHALL keep the count unchanged.
REQ-034 Latency: handshake at cycle N with rsp at N+k SHALL give if_valid at N+k+1 when the FIFO was empty.

Reset
REQ-035 While rst_n=0, outputs SHALL be immediately: imem_req_valid 0, imem_req_addr RESET_PC, if_valid 0, if_pc 0, if_instr 32'h0000_0013, fetch_fault 0; state SHALL be IDLE and the FIFO empty.
REQ-036 A reset asserted mid-request SHALL abandon the outstanding request; a stale response after release SHALL be ignored per REQ-028.

Verification
REQ-037 RESET_PC=0x100, req_ready=1, rsp 1 cycle after accept, id_ready=1 -> requests 0x100, 0x104, 0x108; if_pc in the same order.
REQ-038 id_ready=0 -> two entries buffered, imem_req_valid low; id_ready=1 -> pops 2, then fetching resumes at the next sequential PC.
REQ-039 br_taken in WAIT, br_pc=0x200, br_offset=0x20 -> FIFO empties, next rsp dropped, next request 0x22C.
REQ-040 br_pc=0x200, br_offset=-10 -> fetch_fault pulses once; next request 0x200.
REQ-041 PC=0xFFFF_FFFC accepted -> next request 0x0000_0000.
REQ-042 rst_n low during WAIT -> outputs at reset values without a clock edge; rsp after release ignored; first request RESET_PC.
